// File: rtl/sar_fsm_nbit.sv
// sar_fsm_nbit: N-bit successive-approximation conversion controller.
// Runs sample phase, then resolves one bit per step from MSB to LSB using
// the external comparator, and publishes the code with a one-cycle VALID.
// Optional continuous mode chains conversions back-to-back while enabled.
module sar_fsm_nbit #(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int CONTINUOUS    = 0
) (
  input  logic             CLK,
  input  logic             VRESET,
  input  logic             VENABLE,
  input  logic             VCOMP,
  output logic             VSAMPLE,
  output logic [NBITS-1:0] DAC_CODE,
  output logic [NBITS-1:0] RESULT,
  output logic             VALID,
  output logic             BUSY,
  output logic             BITOUT,
  output logic             BITSTB,
  output logic [2:0]       VOUT
);

  // Counter widths; a limit of one (or zero settle) still needs a 1-bit counter.
  localparam int BIT_W    = $clog2(NBITS);
  localparam int SAMP_W   = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [SAMP_W-1:0]   SAMP_LAST   = SAMP_W'(SAMPLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [BIT_W-1:0]    MSB_IDX     = BIT_W'(NBITS - 1);
  localparam logic [NBITS-1:0]    MSB_TRIAL   = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic                CONT_EN     = (CONTINUOUS != 0);

  // State encoding doubles as the external state code on VOUT.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b100,
    ST_SAMPLE  = 3'b010,
    ST_CONVERT = 3'b001,
    ST_DONE    = 3'b000
  } state_t;

  state_t              state_reg;
  logic [SAMP_W-1:0]   samp_cnt_reg;
  logic [SETTLE_W-1:0] settle_cnt_reg;
  logic [BIT_W-1:0]    bit_idx_reg;
  logic [NBITS-1:0]    dac_code_reg;
  logic [NBITS-1:0]    result_reg;
  logic                valid_reg;
  logic                bitout_reg;
  logic                bitstb_reg;

  logic [BIT_W-1:0]    bit_idx_m1;
  logic [NBITS-1:0]    code_decided;
  logic [NBITS-1:0]    next_trial;

  // Current trial with bit i resolved by the comparator, and the next trial
  // that additionally sets bit i-1 (only used when i > 0).
  always_comb begin
    bit_idx_m1               = bit_idx_reg - 1'b1;
    code_decided             = dac_code_reg;
    code_decided[bit_idx_reg] = VCOMP;
    next_trial               = code_decided;
    next_trial[bit_idx_m1]   = 1'b1;
  end

  // Conversion sequencer: state, counters, trial code and all registered outputs.
  always_ff @(posedge CLK or posedge VRESET) begin
    if (VRESET) begin
      state_reg      <= ST_IDLE;
      samp_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
      bit_idx_reg    <= '0;
      dac_code_reg   <= '0;
      result_reg     <= '0;
      valid_reg      <= 1'b0;
      bitout_reg     <= 1'b0;
      bitstb_reg     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      valid_reg  <= 1'b0;
      bitstb_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          dac_code_reg <= '0;
          if (VENABLE) begin
            state_reg    <= ST_SAMPLE;
            samp_cnt_reg <= '0;
          end
        end

        ST_SAMPLE: begin
          dac_code_reg <= '0;
          if (!VENABLE) begin
            state_reg <= ST_IDLE;
          end else if (samp_cnt_reg == SAMP_LAST) begin
            // First trial of the conversion: MSB set, everything else clear.
            state_reg      <= ST_CONVERT;
            bit_idx_reg    <= MSB_IDX;
            settle_cnt_reg <= '0;
            dac_code_reg   <= MSB_TRIAL;
          end else begin
            samp_cnt_reg <= samp_cnt_reg + 1'b1;
          end
        end

        ST_CONVERT: begin
          if (!VENABLE) begin
            // Abort discards partial bits and suppresses any decision due now.
            state_reg    <= ST_IDLE;
            dac_code_reg <= '0;
          end else if (settle_cnt_reg == SETTLE_LAST) begin
            bitout_reg <= VCOMP;
            bitstb_reg <= 1'b1;
            if (bit_idx_reg == '0) begin
              state_reg    <= ST_DONE;
              dac_code_reg <= code_decided;
              result_reg   <= code_decided;
              valid_reg    <= 1'b1;
            end else begin
              bit_idx_reg    <= bit_idx_m1;
              dac_code_reg   <= next_trial;
              settle_cnt_reg <= '0;
            end
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end

        ST_DONE: begin
          // VENABLE only matters here for chaining in continuous mode.
          dac_code_reg <= '0;
          if (CONT_EN && VENABLE) begin
            state_reg    <= ST_SAMPLE;
            samp_cnt_reg <= '0;
          end else begin
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg    <= ST_IDLE;
          dac_code_reg <= '0;
        end
      endcase
    end
  end

  // Outputs driven from registers or decoded directly from the state register.
  always_comb begin
    VOUT     = state_reg;
    VSAMPLE  = (state_reg == ST_SAMPLE);
    BUSY     = (state_reg == ST_SAMPLE) || (state_reg == ST_CONVERT);
    DAC_CODE = dac_code_reg;
    RESULT   = result_reg;
    VALID    = valid_reg;
    BITOUT   = bitout_reg;
    BITSTB   = bitstb_reg;
  end

endmodule

// File: tb/tb_sar_fsm_nbit.sv
// tb_sar_fsm_nbit: directed bench for the SAR controller. Three instances
// cover the default build, continuous mode and a 4-bit zero-settle build.
// Comparator is modelled as VCOMP = (Vin >= DAC_CODE).
module tb_sar_fsm_nbit;

  logic CLK = 1'b0;
  logic VRESET;
  always #5 CLK = ~CLK;

  // Default instance (NBITS=8, SAMPLE=2, SETTLE=1, one-shot)
  logic       en_a, comp_a, vsample_a, valid_a, busy_a, bitout_a, bitstb_a;
  logic [7:0] vin_a, dac_a, result_a;
  logic [2:0] vout_a;
  assign comp_a = (vin_a >= dac_a);

  // Continuous instance
  logic       en_b, comp_b, vsample_b, valid_b, busy_b, bitout_b, bitstb_b;
  logic [7:0] vin_b, dac_b, result_b;
  logic [2:0] vout_b;
  assign comp_b = (vin_b >= dac_b);

  // Small instance (NBITS=4, SAMPLE=1, SETTLE=0)
  logic       en_c, comp_c, vsample_c, valid_c, busy_c, bitout_c, bitstb_c;
  logic [3:0] vin_c, dac_c, result_c;
  logic [2:0] vout_c;
  assign comp_c = (vin_c >= dac_c);

  sar_fsm_nbit dut_a (
    .CLK(CLK), .VRESET(VRESET), .VENABLE(en_a), .VCOMP(comp_a),
    .VSAMPLE(vsample_a), .DAC_CODE(dac_a), .RESULT(result_a), .VALID(valid_a),
    .BUSY(busy_a), .BITOUT(bitout_a), .BITSTB(bitstb_a), .VOUT(vout_a)
  );

  sar_fsm_nbit #(.CONTINUOUS(1)) dut_b (
    .CLK(CLK), .VRESET(VRESET), .VENABLE(en_b), .VCOMP(comp_b),
    .VSAMPLE(vsample_b), .DAC_CODE(dac_b), .RESULT(result_b), .VALID(valid_b),
    .BUSY(busy_b), .BITOUT(bitout_b), .BITSTB(bitstb_b), .VOUT(vout_b)
  );

  sar_fsm_nbit #(.NBITS(4), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) dut_c (
    .CLK(CLK), .VRESET(VRESET), .VENABLE(en_c), .VCOMP(comp_c),
    .VSAMPLE(vsample_c), .DAC_CODE(dac_c), .RESULT(result_c), .VALID(valid_c),
    .BUSY(busy_c), .BITOUT(bitout_c), .BITSTB(bitstb_c), .VOUT(vout_c)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] vin;
    logic [7:0] exp_result;
    logic [7:0] exp_bits;
    int         exp_valid_edge;
  } vec_t;

  vec_t vecs[5];

  // One full conversion on dut_a; edge 1 is the first edge seeing VENABLE=1.
  task automatic run_a(input logic [7:0] vin, output int valid_edge, output logic [7:0] bits,
                       output int nstb, output logic [7:0] first_dac, output logic [7:0] dac_at_valid);
    logic seen;
    seen         = 1'b0;
    valid_edge   = -1;
    bits         = '0;
    nstb         = 0;
    first_dac    = '0;
    dac_at_valid = '0;
    @(negedge CLK);
    vin_a = vin;
    en_a  = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge CLK); #1;
      if (bitstb_a) begin
        bits = {bits[6:0], bitout_a};
        nstb++;
      end
      if (!seen && vout_a == 3'b001) begin
        first_dac = dac_a;
        seen      = 1'b1;
      end
      if (valid_a) begin
        valid_edge   = e;
        dac_at_valid = dac_a;
        en_a         = 1'b0;
        break;
      end
    end
    en_a = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " vout"},    32'(vout_a), 'b100);
    chk({tag, " dac"},     32'(dac_a), 0);
    chk({tag, " result"},  32'(result_a), 0);
    chk({tag, " valid"},   32'(valid_a), 0);
    chk({tag, " busy"},    32'(busy_a), 0);
    chk({tag, " bitout"},  32'(bitout_a), 0);
    chk({tag, " bitstb"},  32'(bitstb_a), 0);
    chk({tag, " vsample"}, 32'(vsample_a), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         vedge, nstb;
    logic [7:0] bits, first_dac, dac_v;
    int         nvalid;
    logic       saw_valid;

    vecs[0] = '{vin: 8'h00, exp_result: 8'h00, exp_bits: 8'h00, exp_valid_edge: 19};
    vecs[1] = '{vin: 8'hFF, exp_result: 8'hFF, exp_bits: 8'hFF, exp_valid_edge: 19};
    vecs[2] = '{vin: 8'h80, exp_result: 8'h80, exp_bits: 8'h80, exp_valid_edge: 19};
    vecs[3] = '{vin: 8'h7F, exp_result: 8'h7F, exp_bits: 8'h7F, exp_valid_edge: 19};
    vecs[4] = '{vin: 8'hA5, exp_result: 8'hA5, exp_bits: 8'hA5, exp_valid_edge: 19};

    VRESET = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    vin_a = '0; vin_b = '0; vin_c = '0;

    // Asynchronous reset before any clock edge
    #2 VRESET = 1'b1;
    #1 check_reset_values("init");
    repeat (2) @(posedge CLK);
    @(negedge CLK) VRESET = 1'b0;
    $display("reset: initial outputs checked");

    // Table of one-shot conversions on the default build
    for (int i = 0; i < 5; i++) begin
      run_a(vecs[i].vin, vedge, bits, nstb, first_dac, dac_v);
      chk("valid_edge", 32'(vedge), 32'(vecs[i].exp_valid_edge));
      chk("result",     32'(result_a), 32'(vecs[i].exp_result));
      chk("bit_seq",    32'(bits), 32'(vecs[i].exp_bits));
      chk("bitstb_cnt", 32'(nstb), 8);
      chk("first_trial", 32'(first_dac), 'h80);
      chk("dac_in_done", 32'(dac_v), 32'(vecs[i].exp_result));
      @(posedge CLK); #1;
      chk("valid_one_cycle", 32'(valid_a), 0);
      chk("back_to_idle",    32'(vout_a), 'b100);
      $display("vec %0d: vin=0x%0h result=0x%0h bits=0x%0h valid_edge=%0d", i, vecs[i].vin, result_a, bits, vedge);
    end

    // Abort: VENABLE dropped after edge 8, sampled low at edge 9 (a decision edge)
    saw_valid = 1'b0;
    @(negedge CLK);
    vin_a = 8'h5A;
    en_a  = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge CLK); #1;
      if (valid_a) saw_valid = 1'b1;
      if (e == 8) en_a = 1'b0;
      if (e == 9) begin
        chk("abort_vout",   32'(vout_a), 'b100);
        chk("abort_bitstb", 32'(bitstb_a), 0);
        chk("abort_bitout", 32'(bitout_a), 1);
        chk("abort_busy",   32'(busy_a), 0);
      end
    end
    chk("abort_no_valid",    32'(saw_valid), 0);
    chk("abort_result_held", 32'(result_a), 'hA5);
    $display("abort: vin=0x5A result held at 0x%0h", result_a);

    // Asynchronous reset mid-CONVERT, between clock edges
    @(negedge CLK);
    vin_a = 8'h96;
    en_a  = 1'b1;
    repeat (10) @(posedge CLK);
    #1 chk("pre_reset_convert", 32'(vout_a), 'b001);
    #2 VRESET = 1'b1;
    #1 check_reset_values("midreset");
    en_a = 1'b0;
    @(negedge CLK) VRESET = 1'b0;
    run_a(8'h3C, vedge, bits, nstb, first_dac, dac_v);
    chk("post_reset_edge",   32'(vedge), 19);
    chk("post_reset_result", 32'(result_a), 'h3C);
    @(posedge CLK); #1;
    $display("midreset: fresh conversion result=0x%0h valid_edge=%0d", result_a, vedge);

    // Continuous mode: back-to-back conversions every 19 cycles
    nvalid = 0;
    @(negedge CLK);
    vin_b = 8'h3C;
    en_b  = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge CLK); #1;
      if (valid_b) begin
        if (nvalid == 0) begin
          chk("cont_edge1",   32'(e), 19);
          chk("cont_result1", 32'(result_b), 'h3C);
          vin_b = 8'hC3;
        end else begin
          chk("cont_edge2",   32'(e), 38);
          chk("cont_result2", 32'(result_b), 'hC3);
          en_b = 1'b0;
        end
        nvalid++;
        if (nvalid == 2) break;
      end
    end
    en_b = 1'b0;
    chk("cont_valid_count", 32'(nvalid), 2);
    @(posedge CLK); #1;
    chk("cont_stop_idle", 32'(vout_b), 'b100);
    $display("continuous: %0d results, last=0x%0h", nvalid, result_b);

    // 4-bit, single sample cycle, zero settle: VALID at edge 6
    vedge = -1;
    bits  = '0;
    first_dac = '0;
    @(negedge CLK);
    vin_c = 4'h9;
    en_c  = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge CLK); #1;
      if (e == 2) first_dac = {4'h0, dac_c};
      if (bitstb_c) bits = {bits[6:0], bitout_c};
      if (valid_c) begin
        vedge = e;
        en_c  = 1'b0;
        break;
      end
    end
    en_c = 1'b0;
    chk("small_edge",        32'(vedge), 6);
    chk("small_result",      32'(result_c), 'h9);
    chk("small_bits",        32'(bits), 'h9);
    chk("small_first_trial", 32'(first_dac), 'h8);
    $display("small: result=0x%0h valid_edge=%0d", result_c, vedge);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
